id_ex_stage: RTL and testbench

- Decode/execute pipeline register that sits directly upstream of the ALU.
- Captures decoded operands, immediate, PC and control from decode.
- Applies stall/flush control.
- Resolves RAW hazards by forwarding results from the EX/MEM and MEM/WB stages.
- Drives srcA, srcB and alu_fun to the ALU, plus rd/reg_write and store data to the downstream stages.

---
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : Signal bundle between decode, the ID/EX register, the ALU and
//               the later pipeline stages that supply forwarded results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [1:0]      id_srcA_sel;
    logic [1:0]      id_srcB_sel;
    logic [3:0]      id_alu_fun;
    logic [RA_W-1:0] id_rd_addr;
    logic            id_reg_write;
    logic [RA_W-1:0] exm_rd;
    logic [RA_W-1:0] wb_rd;
    logic            exm_reg_write;
    logic            wb_reg_write;
    logic [XLEN-1:0] exm_result;
    logic [XLEN-1:0] wb_result;
    logic            ex_valid;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [3:0]      alu_fun;
    logic [XLEN-1:0] ex_rs2_fwd;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_write;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rs1_data, id_rs2_data, id_imm, id_srcA_sel, id_srcB_sel,
               id_alu_fun, id_rd_addr, id_reg_write, exm_rd, wb_rd,
               exm_reg_write, wb_reg_write, exm_result, wb_result,
        input  id_ready, ex_valid, srcA, srcB, alu_fun, ex_rs2_fwd, ex_pc,
               ex_rd_addr, ex_reg_write
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rs1_data, id_rs2_data, id_imm, id_srcA_sel, id_srcB_sel,
               id_alu_fun, id_rd_addr, id_reg_write, exm_rd, wb_rd,
               exm_reg_write, wb_reg_write, exm_result, wb_result,
        output id_ready, ex_valid, srcA, srcB, alu_fun, ex_rs2_fwd, ex_pc,
               ex_rd_addr, ex_reg_write
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with flush/stall control, operand
//               muxing and optional EX/MEM + MEM/WB forwarding (ID_EX_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    id_ex_stage_if.slave bus
);

    localparam logic [1:0] SEL_ZERO = 2'd3;

    logic            valid_q,     valid_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [RA_W-1:0] rs1_addr_q,  rs1_addr_d;
    logic [RA_W-1:0] rs2_addr_q,  rs2_addr_d;
    logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [1:0]      srca_sel_q,  srca_sel_d;
    logic [1:0]      srcb_sel_q,  srcb_sel_d;
    logic [3:0]      alu_fun_q,   alu_fun_d;
    logic [RA_W-1:0] rd_q,        rd_d;
    logic            reg_write_q, reg_write_d;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Flush beats stall: a bubble (zero + zero, no write) is loaded either way.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        srca_sel_d  = srca_sel_q;
        srcb_sel_d  = srcb_sel_q;
        alu_fun_d   = alu_fun_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            srca_sel_d  = SEL_ZERO;
            srcb_sel_d  = SEL_ZERO;
            alu_fun_d   = 4'b0000;
            rd_d        = '0;
            reg_write_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.id_valid;
            pc_d        = bus.id_pc;
            rs1_addr_d  = bus.id_rs1_addr;
            rs2_addr_d  = bus.id_rs2_addr;
            rs1_data_d  = bus.id_rs1_data;
            rs2_data_d  = bus.id_rs2_data;
            imm_d       = bus.id_imm;
            srca_sel_d  = bus.id_srcA_sel;
            srcb_sel_d  = bus.id_srcB_sel;
            alu_fun_d   = bus.id_alu_fun;
            rd_d        = bus.id_rd_addr;
            reg_write_d = bus.id_reg_write & bus.id_valid;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            srca_sel_q  <= 2'd0;
            srcb_sel_q  <= 2'd0;
            alu_fun_q   <= 4'b0000;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            srca_sel_q  <= srca_sel_d;
            srcb_sel_q  <= srcb_sel_d;
            alu_fun_q   <= alu_fun_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rs1_addr_q))
            rs1_fwd = bus.exm_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs1_addr_q))
            rs1_fwd = bus.wb_result;
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rs2_addr_q))
            rs2_fwd = bus.exm_result;
        else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs2_addr_q))
            rs2_fwd = bus.wb_result;
    end
`else
    logic w_unused_fwd;

    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;
    assign w_unused_fwd = ^{bus.exm_rd, bus.exm_reg_write, bus.exm_result,
                            bus.wb_rd, bus.wb_reg_write, bus.wb_result,
                            rs1_addr_q, rs2_addr_q};
`endif

    always_comb begin
        bus.srcA = '0;
        case (srca_sel_q)
            2'd0:    bus.srcA = rs1_fwd;
            2'd1:    bus.srcA = imm_q;
            2'd2:    bus.srcA = pc_q;
            default: bus.srcA = '0;
        endcase
    end

    always_comb begin
        bus.srcB = '0;
        case (srcb_sel_q)
            2'd0:    bus.srcB = rs2_fwd;
            2'd1:    bus.srcB = imm_q;
            2'd2:    bus.srcB = XLEN'(4);
            default: bus.srcB = '0;
        endcase
    end

    assign bus.id_ready     = ~bus.stall;
    assign bus.ex_valid     = valid_q;
    assign bus.alu_fun      = alu_fun_q;
    assign bus.ex_rs2_fwd   = rs2_fwd;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_rd_addr   = rd_q;
    assign bus.ex_reg_write = reg_write_q & valid_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus stall/flush/reset sequences.
`default_nettype none

module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    id_ex_stage_if #(.XLEN(32), .RA_W(5)) ifc ();

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] rs1d, rs2d, imm;
        logic [1:0]  asel, bsel;
        logic [3:0]  fun;
        logic [4:0]  rd;
        logic        rw;
        logic [4:0]  exm_rd;
        logic        exm_rw;
        logic [31:0] exm_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_res;
        logic [31:0] ea_f, ea_n, eb_f, eb_n, es_f, es_n;
        logic        ev, erw;
    } vec_t;

    vec_t vecs[8];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_id(input vec_t t);
        ifc.id_valid     = t.v;
        ifc.id_pc        = t.pc;
        ifc.id_rs1_addr  = t.rs1a;
        ifc.id_rs2_addr  = t.rs2a;
        ifc.id_rs1_data  = t.rs1d;
        ifc.id_rs2_data  = t.rs2d;
        ifc.id_imm       = t.imm;
        ifc.id_srcA_sel  = t.asel;
        ifc.id_srcB_sel  = t.bsel;
        ifc.id_alu_fun   = t.fun;
        ifc.id_rd_addr   = t.rd;
        ifc.id_reg_write = t.rw;
    endtask

    task automatic clear_fwd();
        ifc.exm_rd = '0; ifc.exm_reg_write = 1'b0; ifc.exm_result = '0;
        ifc.wb_rd  = '0; ifc.wb_reg_write  = 1'b0; ifc.wb_result  = '0;
    endtask

    initial begin
        vec_t t;
        //          v  pc        rs1a rs2a rs1d      rs2d      imm            as    bs    fun   rd    rw    exm_rd exw  exm_res   wb_rd wbw  wb_res    ea_f           ea_n           eb_f      eb_n      es_f      es_n      ev    erw
        vecs[0] = '{1'b1, 32'h40,  5'd1, 5'd2, 32'd5,   32'd9,   32'd7,         2'd0, 2'd1, 4'h0, 5'd3, 1'b1, 5'd0,  1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'd5,         32'd5,         32'd7,    32'd7,    32'd9,    32'd9,    1'b1, 1'b1};
        vecs[1] = '{1'b1, 32'h44,  5'd4, 5'd5, 32'h55,  32'h66,  32'h0,         2'd0, 2'd0, 4'h2, 5'd6, 1'b1, 5'd4,  1'b1, 32'h11,  5'd4, 1'b1, 32'h22,  32'h11,        32'h55,        32'h66,   32'h66,   32'h66,   32'h66,   1'b1, 1'b1};
        vecs[2] = '{1'b1, 32'h44,  5'd4, 5'd5, 32'h55,  32'h66,  32'h0,         2'd0, 2'd0, 4'h2, 5'd6, 1'b1, 5'd4,  1'b0, 32'h11,  5'd4, 1'b1, 32'h22,  32'h22,        32'h55,        32'h66,   32'h66,   32'h66,   32'h66,   1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h48,  5'd0, 5'd5, 32'h0,   32'h66,  32'h0,         2'd0, 2'd0, 4'h1, 5'd6, 1'b1, 5'd0,  1'b1, 32'h11,  5'd0, 1'b1, 32'h22,  32'h0,         32'h0,         32'h66,   32'h66,   32'h66,   32'h66,   1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h100, 5'd7, 5'd8, 32'h33,  32'h10,  32'h0,         2'd2, 2'd2, 4'h3, 5'd7, 1'b1, 5'd7,  1'b0, 32'h0,   5'd8, 1'b0, 32'h0,   32'h100,       32'h100,       32'd4,    32'd4,    32'h10,   32'h10,   1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h104, 5'd1, 5'd9, 32'h2,   32'h01,  32'h0,         2'd3, 2'd0, 4'h0, 5'd0, 1'b0, 5'd9,  1'b1, 32'hAB,  5'd0, 1'b0, 32'h0,   32'h0,         32'h0,         32'hAB,   32'h01,   32'hAB,   32'h01,   1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h108, 5'd2, 5'd10, 32'h3,  32'h5,   32'h123,       2'd1, 2'd0, 4'h8, 5'd11, 1'b1, 5'd10, 1'b0, 32'hEE, 5'd10, 1'b1, 32'hCC, 32'h123,       32'h123,       32'hCC,   32'h5,    32'hCC,   32'h5,    1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h10C, 5'd1, 5'd2, 32'h1,   32'h2,   32'hFFFF_FFF0, 2'd1, 2'd3, 4'h1, 5'd5, 1'b1, 5'd0,  1'b0, 32'h0,   5'd0, 1'b0, 32'h0,   32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0,    32'h0,    32'h2,    32'h2,    1'b0, 1'b0};

        // Reset state
        RST = 1'b1; ifc.stall = 1'b0; ifc.flush = 1'b0;
        drive_id(vecs[0]); clear_fwd();
        #12;
        chk("rst_ex_valid", 32'(ifc.ex_valid), 32'd0);
        chk("rst_ex_reg_write", 32'(ifc.ex_reg_write), 32'd0);
        chk("rst_alu_fun", 32'(ifc.alu_fun), 32'd0);
        chk("rst_srcA", ifc.srcA, 32'd0);
        chk("rst_srcB", ifc.srcB, 32'd0);
        chk("rst_ex_pc", ifc.ex_pc, 32'd0);
        chk("rst_ex_rd", 32'(ifc.ex_rd_addr), 32'd0);
        chk("rst_id_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b0;

        // Table-driven captures; forwarding sources applied after the capture edge
        for (int i = 0; i < 8; i++) begin
            drive_id(vecs[i]); clear_fwd();
            @(posedge CLK); #1;
            ifc.exm_rd = vecs[i].exm_rd; ifc.exm_reg_write = vecs[i].exm_rw; ifc.exm_result = vecs[i].exm_res;
            ifc.wb_rd  = vecs[i].wb_rd;  ifc.wb_reg_write  = vecs[i].wb_rw;  ifc.wb_result  = vecs[i].wb_res;
            #1;
            chk($sformatf("v%0d_srcA", i), ifc.srcA, FWD ? vecs[i].ea_f : vecs[i].ea_n);
            chk($sformatf("v%0d_srcB", i), ifc.srcB, FWD ? vecs[i].eb_f : vecs[i].eb_n);
            chk($sformatf("v%0d_rs2_fwd", i), ifc.ex_rs2_fwd, FWD ? vecs[i].es_f : vecs[i].es_n);
            chk($sformatf("v%0d_alu_fun", i), 32'(ifc.alu_fun), 32'(vecs[i].fun));
            chk($sformatf("v%0d_ex_valid", i), 32'(ifc.ex_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d_ex_reg_write", i), 32'(ifc.ex_reg_write), 32'(vecs[i].erw));
            chk($sformatf("v%0d_ex_rd", i), 32'(ifc.ex_rd_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d_ex_pc", i), ifc.ex_pc, vecs[i].pc);
        end

        // Stall holds EX for three cycles while decode keeps changing
        clear_fwd();
        t = vecs[0];
        t.pc = 32'h200; t.rs1a = 5'd4; t.rs1d = 32'd5; t.imm = 32'h9; t.fun = 4'h5; t.rd = 5'd3;
        drive_id(t);
        @(posedge CLK); #1;
        chk("stall_pre_srcA", ifc.srcA, 32'd5);
        chk("stall_pre_srcB", ifc.srcB, 32'h9);
        ifc.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t.pc = 32'h300 + 32'(k); t.rs1d = 32'hDEAD; t.imm = 32'hBEEF; t.fun = 4'hF;
            t.rd = 5'(10 + k); t.v = k[0]; t.asel = 2'd2;
            drive_id(t);
            #1;
            chk($sformatf("stall%0d_id_ready", k), 32'(ifc.id_ready), 32'd0);
            @(posedge CLK); #1;
            chk($sformatf("stall%0d_srcA", k), ifc.srcA, 32'd5);
            chk($sformatf("stall%0d_srcB", k), ifc.srcB, 32'h9);
            chk($sformatf("stall%0d_alu_fun", k), 32'(ifc.alu_fun), 32'h5);
            chk($sformatf("stall%0d_ex_rd", k), 32'(ifc.ex_rd_addr), 32'd3);
            chk($sformatf("stall%0d_ex_pc", k), ifc.ex_pc, 32'h200);
            chk($sformatf("stall%0d_ex_valid", k), 32'(ifc.ex_valid), 32'd1);
        end
        // Producer result arriving while stalled
        ifc.exm_rd = 5'd4; ifc.exm_reg_write = 1'b1; ifc.exm_result = 32'h77;
        #1;
        chk("stall_late_fwd_srcA", ifc.srcA, FWD ? 32'h77 : 32'd5);
        clear_fwd();

        // Flush together with stall loads a bubble
        ifc.flush = 1'b1;
        @(posedge CLK); #1;
        chk("flush_ex_valid", 32'(ifc.ex_valid), 32'd0);
        chk("flush_ex_reg_write", 32'(ifc.ex_reg_write), 32'd0);
        chk("flush_alu_fun", 32'(ifc.alu_fun), 32'd0);
        chk("flush_srcA", ifc.srcA, 32'd0);
        chk("flush_srcB", ifc.srcB, 32'd0);
        chk("flush_ex_rd", 32'(ifc.ex_rd_addr), 32'd0);
        ifc.stall = 1'b0;
        #1;
        chk("flush_id_ready", 32'(ifc.id_ready), 32'd1);
        ifc.flush = 1'b0;

        // Asynchronous reset mid-cycle with valid data in EX
        t = vecs[0];
        t.pc = 32'h500; t.fun = 4'h6;
        drive_id(t);
        @(posedge CLK); #1;
        chk("pre_arst_ex_valid", 32'(ifc.ex_valid), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("arst_ex_valid", 32'(ifc.ex_valid), 32'd0);
        chk("arst_ex_reg_write", 32'(ifc.ex_reg_write), 32'd0);
        chk("arst_alu_fun", 32'(ifc.alu_fun), 32'd0);
        chk("arst_srcA", ifc.srcA, 32'd0);
        chk("arst_srcB", ifc.srcB, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        t.pc = 32'h600;
        drive_id(t);
        #1;
        chk("post_rst_pre_edge_valid", 32'(ifc.ex_valid), 32'd0);
        @(posedge CLK); #1;
        chk("post_rst_capture_valid", 32'(ifc.ex_valid), 32'd1);
        chk("post_rst_capture_pc", ifc.ex_pc, 32'h600);
        chk("post_rst_capture_fun", 32'(ifc.alu_fun), 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
